pico_intc: RTL and testbench
============================

Name: pico_intc

Overview:
Multi-source interrupt controller that arbitrates up to 8 interrupt requesters onto the single interrupt/interrupt_ack pair of the kcpsm3 processor. Sits between the I/O modules (10 us timer tick, debounced button ticks, future UART) and the processor. Provides pending, mask, current-ID and end-of-interrupt (EOI) registers on the processor port bus. Guarantees one interrupt in service at a time.

Parameters:
N_SRC, 4, number of interrupt sources, 1..8
BASE_ID, 8'h10, port_id base; block decodes BASE_ID..BASE_ID+3 (BASE_ID[1:0] must be 2'b00)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
irq_src  in  N_SRC  source request lines; a rising edge (or a 1-cycle tick) raises the request
port_id  in  8  processor port address
write_strobe  in  1  processor write qualifier
read_strobe  in  1  processor read qualifier
out_port  in  8  processor write data
in_port  out  8  read data (combinational from port_id)
in_sel  out  1  high when port_id[7:2]==BASE_ID[7:2]; top-level input mux uses it
interrupt  out  1  to kcpsm3 interrupt
interrupt_ack  in  1  from kcpsm3 interrupt_ack

Behaviour:
- Reset (reset_n=0, async): pending=0, mask=0 (all disabled), cur_id=0, active=0, src_q=0, state=IDLE, interrupt=0.
- Edge detect: src_q <= irq_src each cycle; set_vec = irq_src & ~src_q. A set_vec bit sets its pending bit regardless of mask.
- Register map (offset = port_id[1:0]):
  0 PENDING: read {0, pending}; write-1-to-clear.
  1 MASK: read/write, bit i=1 enables source i; bits >= N_SRC read 0 and ignore writes.
  2 CUR_ID: read-only {active, 4'b0, cur_id[2:0]}.
  3 EOI: any write while in SERVICE -> IDLE, active=0; ignored in other states.
- Writes take effect on the clk edge where write_strobe=1 and in_sel=1. Reads are side-effect free.
- Simultaneous set and W1C clear of the same bit: set wins (bit stays 1).
- eligible = pending & mask.
- FSM:
  IDLE: if eligible!=0 -> REQ.
  REQ: interrupt=1. On interrupt_ack: winner = lowest-index eligible bit; cur_id<=winner; clear pending[winner] (unless set_vec on the same bit in that cycle); active<=1 -> SERVICE. If eligible drops to 0 before ack (mask or W1C write): deassert, -> IDLE. If an ack arrives when eligible==0 it is ignored.
  SERVICE: interrupt=0; new edges accumulate in pending; wait for EOI.
- interrupt is registered: it rises 1 cycle after eligible becomes nonzero in IDLE. Pending set to interrupt high takes 2 cycles.
- Winner is evaluated at the ack cycle, not at REQ entry, so a higher-priority source arriving during REQ is served first.
- Mid-operation reset: returns to reset values immediately; in-flight edges are lost.
- No nesting: the kcpsm3 masks interrupts during the ISR, and the block holds off until EOI.

Optional Feature:
PICO_INTC_RR_EN. When defined: round-robin priority. A last_id register (reset 0) is kept, and the winner is the first eligible index scanning upward from last_id+1 modulo N_SRC. last_id<=winner on ack. When undefined: fixed priority, index 0 highest, and no last_id register.

Decomposition:
- Package pico_intc_pkg holds:
  - register offset constants OFS_PENDING=0, OFS_MASK=1, OFS_CURID=2, OFS_EOI=3;
  - state enum IDLE/REQ/SERVICE (2-bit encoding);
  - MAX_SRC=8.
- One sub-module, pico_intc_prio: combinational priority picker. Inputs are eligible and a start index; outputs are winner[2:0] and valid. Fixed priority uses start=0.

Test Plan:
- Reset, mask=0, pulse irq_src[1] -> PENDING reads 8'h02, interrupt stays 0. Write MASK=8'h02 -> interrupt=1 two cycles later.
- MASK=8'h0F, assert src0 and src2 in the same cycle, ack -> CUR_ID=8'h80, PENDING=8'h04, interrupt=0. Write EOI -> interrupt reasserts. Ack -> CUR_ID=8'h82.
- In REQ with src2 pending, assert src1 one cycle before ack -> CUR_ID=8'h81 and pending[2] remains set.
- In SERVICE, pulse src3 and write PENDING=8'h08 in the same cycle -> pending[3]=1 (set wins). Write EOI in IDLE -> no state change.
- In REQ, write MASK=0 before ack -> interrupt drops next cycle, state IDLE. A late ack is ignored and CUR_ID is unchanged.
- With PICO_INTC_RR_EN, all 4 sources kept pending -> successive ack/EOI cycles give CUR_ID low bits 1,2,3,0. Assert reset_n=0 mid-SERVICE -> interrupt=0, all registers 0 asynchronously.

Source files
------------

// File: rtl/pico_intc_pkg.sv
// Shared constants and types for the pico_intc interrupt controller.
// Register offsets, FSM state encoding and source-count limits live here.
package pico_intc_pkg;

    localparam int MAX_SRC = 8;
    localparam int ID_W    = 3;

    localparam logic [1:0] OFS_PENDING = 2'd0;
    localparam logic [1:0] OFS_MASK    = 2'd1;
    localparam logic [1:0] OFS_CURID   = 2'd2;
    localparam logic [1:0] OFS_EOI     = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_e;

endpackage

// File: rtl/pico_intc_if.sv
// kcpsm3 port bus plus interrupt/interrupt_ack pair as seen by pico_intc.
// The master modport is the processor side; the slave modport is the controller.
interface pico_intc_if;
    import pico_intc_pkg::*;

    logic [7:0] port_id;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic       in_sel;
    logic       interrupt;
    logic       interrupt_ack;

    modport master (
        output port_id, write_strobe, read_strobe, out_port, interrupt_ack,
        input  in_port, in_sel, interrupt
    );

    modport slave (
        input  port_id, write_strobe, read_strobe, out_port, interrupt_ack,
        output in_port, in_sel, interrupt
    );

endinterface

// File: rtl/pico_intc_prio.sv
// Combinational priority picker: returns the first set bit of eligible found
// by scanning upward from start (wrapping modulo N_SRC).
module pico_intc_prio
    import pico_intc_pkg::*;
#(
    parameter int N_SRC = 4
) (
    input  logic [N_SRC-1:0] eligible,
    input  logic [ID_W-1:0]  start,
    output logic [ID_W-1:0]  winner,
    output logic             valid
);

    // Scan from the farthest offset down so the nearest hit overwrites the rest.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            idx = (int'(start) + i) % N_SRC;
            if (eligible[idx]) begin
                winner = ID_W'(idx);
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pico_intc.sv
// Multi-source interrupt controller for kcpsm3: edge-captured pending bits,
// mask, current-ID and EOI registers. Define PICO_INTC_RR_EN for round-robin.
module pico_intc
    import pico_intc_pkg::*;
#(
    parameter int         N_SRC   = 4,
    parameter logic [7:0] BASE_ID = 8'h10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_SRC-1:0] irq_src,
    pico_intc_if.slave       bus
);

    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] pending_q, pending_d;
    logic [N_SRC-1:0] mask_q, mask_d;
    logic [ID_W-1:0]  cur_id_q, cur_id_d;
    logic             active_q, active_d;
    logic             interrupt_q, interrupt_d;
    state_e           state_q, state_d;

    logic [N_SRC-1:0] set_vec;
    logic [N_SRC-1:0] eligible;
    logic [N_SRC-1:0] wr_bits;
    logic [N_SRC-1:0] win_onehot;
    logic [ID_W-1:0]  start;
    logic [ID_W-1:0]  winner;
    logic             win_valid;
    logic             wr_en;
    logic [1:0]       ofs;
    logic [7:0]       rd_data;
    logic             unused_ok;

    assign ofs        = bus.port_id[1:0];
    assign bus.in_sel = (bus.port_id[7:2] == BASE_ID[7:2]);
    assign wr_en      = bus.write_strobe & bus.in_sel;
    assign set_vec    = irq_src & ~src_q;
    assign eligible   = pending_q & mask_q;
    assign wr_bits    = bus.out_port[N_SRC-1:0];
    assign win_onehot = N_SRC'(1) << winner;
    assign unused_ok  = ^{bus.read_strobe, bus.out_port};

`ifdef PICO_INTC_RR_EN
    logic [ID_W-1:0] last_id_q, last_id_d;
    assign start = ID_W'((int'(last_id_q) + 1) % N_SRC);
`else
    assign start = '0;
`endif

    pico_intc_prio #(.N_SRC(N_SRC)) u_prio (
        .eligible (eligible),
        .start    (start),
        .winner   (winner),
        .valid    (win_valid)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        mask_d    = mask_q;
        cur_id_d  = cur_id_q;
        active_d  = active_q;
`ifdef PICO_INTC_RR_EN
        last_id_d = last_id_q;
`endif
        if (wr_en && ofs == OFS_PENDING) pending_d = pending_d & ~wr_bits;
        if (wr_en && ofs == OFS_MASK)    mask_d    = wr_bits;

        case (state_q)
            IDLE: begin
                if (eligible != '0) state_d = REQ;
            end
            REQ: begin
                if (eligible == '0) begin
                    state_d = IDLE;
                end else if (bus.interrupt_ack && win_valid) begin
                    cur_id_d  = winner;
                    pending_d = pending_d & ~win_onehot;
                    active_d  = 1'b1;
                    state_d   = SERVICE;
`ifdef PICO_INTC_RR_EN
                    last_id_d = winner;
`endif
                end
            end
            SERVICE: begin
                if (wr_en && ofs == OFS_EOI) begin
                    state_d  = IDLE;
                    active_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new edge always survives a same-cycle clear, whether W1C or ack.
        pending_d   = pending_d | set_vec;
        interrupt_d = (state_d == REQ);
    end

    always_comb begin
        rd_data = 8'h00;
        case (ofs)
            OFS_PENDING: rd_data = MAX_SRC'(pending_q);
            OFS_MASK:    rd_data = MAX_SRC'(mask_q);
            OFS_CURID:   rd_data = {active_q, 4'b0000, cur_id_q};
            default:     rd_data = 8'h00;
        endcase
        bus.in_port = bus.in_sel ? rd_data : 8'h00;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q       <= '0;
            pending_q   <= '0;
            mask_q      <= '0;
            cur_id_q    <= '0;
            active_q    <= 1'b0;
            interrupt_q <= 1'b0;
            state_q     <= IDLE;
`ifdef PICO_INTC_RR_EN
            last_id_q   <= '0;
`endif
        end else begin
            src_q       <= irq_src;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            cur_id_q    <= cur_id_d;
            active_q    <= active_d;
            interrupt_q <= interrupt_d;
            state_q     <= state_d;
`ifdef PICO_INTC_RR_EN
            last_id_q   <= last_id_d;
`endif
        end
    end

    assign bus.interrupt = interrupt_q;

endmodule

// File: tb/tb_pico_intc.sv
// Directed, table-driven bench for pico_intc (N_SRC=4, BASE_ID=8'h10).
// Fixed-priority vectors run by default; PICO_INTC_RR_EN selects the round-robin sequence.
module tb_pico_intc;
    import pico_intc_pkg::*;

    localparam int         N    = 4;
    localparam logic [7:0] BASE = 8'h10;

    typedef struct {
        logic       wr;
        logic [1:0] wofs;
        logic [7:0] wdata;
        logic [3:0] irq;
        logic       ack;
        logic [1:0] rofs;
        logic [7:0] exp_rd;
        logic       exp_int;
    } vec_t;

    logic         clk;
    logic         reset_n;
    logic [N-1:0] irq_src;
    int           tests;
    int           failures;

    pico_intc_if bus_if ();

    pico_intc #(.N_SRC(N), .BASE_ID(BASE)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .irq_src (irq_src),
        .bus     (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the test finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_value(input string name, input int idx, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s[%0d] got %h want %h", name, idx, got, exp);
        end
    endtask

    task automatic check_output(input string name, input int idx, input logic [7:0] exp_rd, input logic exp_int);
        check_value({name, ".in_port"}, idx, bus_if.in_port, exp_rd);
        check_value({name, ".interrupt"}, idx, {7'b0, bus_if.interrupt}, {7'b0, exp_int});
    endtask

    // One clock of stimulus, then the bus is switched to a side-effect-free read of rofs.
    task automatic apply_stimulus(input logic wr, input logic [1:0] wofs, input logic [7:0] wdata,
                                  input logic [3:0] irq, input logic ack, input logic [1:0] rofs);
        @(negedge clk);
        bus_if.port_id       = BASE | {6'b0, wofs};
        bus_if.write_strobe  = wr;
        bus_if.read_strobe   = 1'b0;
        bus_if.out_port      = wdata;
        bus_if.interrupt_ack = ack;
        irq_src              = irq;
        @(posedge clk);
        #1;
        bus_if.write_strobe  = 1'b0;
        bus_if.interrupt_ack = 1'b0;
        bus_if.read_strobe   = 1'b1;
        bus_if.port_id       = BASE | {6'b0, rofs};
        #1;
    endtask

    task automatic do_reset();
        reset_n              = 1'b0;
        irq_src              = '0;
        bus_if.port_id       = BASE;
        bus_if.write_strobe  = 1'b0;
        bus_if.read_strobe   = 1'b0;
        bus_if.out_port      = 8'h00;
        bus_if.interrupt_ack = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic run_step(input string name, input int idx, input vec_t v);
        apply_stimulus(v.wr, v.wofs, v.wdata, v.irq, v.ack, v.rofs);
        check_output(name, idx, v.exp_rd, v.exp_int);
    endtask

    vec_t vecs[32];
    vec_t rst_seq[5];
    vec_t v;
    logic [2:0] rr_ids[4];
    logic [7:0] rr_pend[4];

    initial begin
        tests    = 0;
        failures = 0;

        vecs[0]  = '{1'b0, OFS_PENDING, 8'h00, 4'b0010, 1'b0, OFS_PENDING, 8'h02, 1'b0};
        vecs[1]  = '{1'b0, OFS_PENDING, 8'h00, 4'b0000, 1'b0, OFS_PENDING, 8'h02, 1'b0};
        vecs[2]  = '{1'b1, OFS_MASK,    8'h02, 4'b0000, 1'b0, OFS_CURID,   8'h00, 1'b0};
        vecs[3]  = '{1'b0, OFS_PENDING, 8'h00, 4'b0000, 1'b0, OFS_PENDING, 8'h02, 1'b1};
        vecs[4]  = '{1'b0, OFS_PENDING, 8'h00, 4'b0000, 1'b1, OFS_CURID,   8'h81, 1'b0};
        vecs[5]  = '{1'b1, OFS_EOI,     8'h00, 4'b0000, 1'b0, OFS_CURID,   8'h01, 1'b0};
        vecs[6]  = '{1'b0, OFS_PENDING, 8'h00, 4'b0000, 1'b0, OFS_PENDING, 8'h00, 1'b0};
        vecs[7]  = '{1'b1, OFS_MASK,    8'h0F, 4'b0000, 1'b0, OFS_MASK,    8'h0F, 1'b0};
        vecs[8]  = '{1'b0, OFS_PENDING, 8'h00, 4'b0101, 1'b0, OFS_PENDING, 8'h05, 1'b0};
        vecs[9]  = '{1'b0, OFS_PENDING, 8'h00, 4'b0000, 1'b0, OFS_PENDING, 8'h05, 1'b1};
        vecs[10] = '{1'b0, OFS_PENDING, 8'h00, 4'b0000, 1'b1, OFS_CURID,   8'h80, 1'b0};
        vecs[11] = '{1'b0, OFS_PENDING, 8'h00, 4'b0000, 1'b0, OFS_PENDING, 8'h04, 1'b0};
        vecs[12] = '{1'b1, OFS_EOI,     8'h00, 4'b0000, 1'b0, OFS_CURID,   8'h00, 1'b0};
        vecs[13] = '{1'b0, OFS_PENDING, 8'h00, 4'b0000, 1'b0, OFS_CURID,   8'h00, 1'b1};
        vecs[14] = '{1'b0, OFS_PENDING, 8'h00, 4'b0000, 1'b1, OFS_CURID,   8'h82, 1'b0};
        vecs[15] = '{1'b1, OFS_EOI,     8'h00, 4'b0000, 1'b0, OFS_PENDING, 8'h00, 1'b0};
        vecs[16] = '{1'b0, OFS_PENDING, 8'h00, 4'b0100, 1'b0, OFS_PENDING, 8'h04, 1'b0};
        vecs[17] = '{1'b0, OFS_PENDING, 8'h00, 4'b0000, 1'b0, OFS_PENDING, 8'h04, 1'b1};
        vecs[18] = '{1'b0, OFS_PENDING, 8'h00, 4'b0010, 1'b0, OFS_PENDING, 8'h06, 1'b1};
        vecs[19] = '{1'b0, OFS_PENDING, 8'h00, 4'b0000, 1'b1, OFS_CURID,   8'h81, 1'b0};
        vecs[20] = '{1'b0, OFS_PENDING, 8'h00, 4'b0000, 1'b0, OFS_PENDING, 8'h04, 1'b0};
        vecs[21] = '{1'b1, OFS_PENDING, 8'h08, 4'b1000, 1'b0, OFS_PENDING, 8'h0C, 1'b0};
        vecs[22] = '{1'b1, OFS_EOI,     8'h00, 4'b0000, 1'b0, OFS_PENDING, 8'h0C, 1'b0};
        vecs[23] = '{1'b1, OFS_PENDING, 8'h0C, 4'b0000, 1'b0, OFS_PENDING, 8'h00, 1'b1};
        vecs[24] = '{1'b0, OFS_PENDING, 8'h00, 4'b0000, 1'b0, OFS_CURID,   8'h01, 1'b0};
        vecs[25] = '{1'b1, OFS_EOI,     8'h00, 4'b0000, 1'b0, OFS_CURID,   8'h01, 1'b0};
        vecs[26] = '{1'b0, OFS_PENDING, 8'h00, 4'b0001, 1'b0, OFS_PENDING, 8'h01, 1'b0};
        vecs[27] = '{1'b0, OFS_PENDING, 8'h00, 4'b0000, 1'b0, OFS_CURID,   8'h01, 1'b1};
        vecs[28] = '{1'b1, OFS_MASK,    8'h00, 4'b0000, 1'b0, OFS_MASK,    8'h00, 1'b1};
        vecs[29] = '{1'b0, OFS_PENDING, 8'h00, 4'b0000, 1'b0, OFS_CURID,   8'h01, 1'b0};
        vecs[30] = '{1'b0, OFS_PENDING, 8'h00, 4'b0000, 1'b1, OFS_CURID,   8'h01, 1'b0};
        vecs[31] = '{1'b0, OFS_PENDING, 8'h00, 4'b0000, 1'b0, OFS_PENDING, 8'h01, 1'b0};

        rst_seq[0] = '{1'b1, OFS_MASK,    8'h06, 4'b0000, 1'b0, OFS_MASK,    8'h06, 1'b0};
        rst_seq[1] = '{1'b0, OFS_PENDING, 8'h00, 4'b0010, 1'b0, OFS_PENDING, 8'h02, 1'b0};
        rst_seq[2] = '{1'b0, OFS_PENDING, 8'h00, 4'b0000, 1'b0, OFS_PENDING, 8'h02, 1'b1};
        rst_seq[3] = '{1'b0, OFS_PENDING, 8'h00, 4'b0000, 1'b1, OFS_CURID,   8'h81, 1'b0};
        rst_seq[4] = '{1'b0, OFS_PENDING, 8'h00, 4'b0100, 1'b0, OFS_PENDING, 8'h04, 1'b0};

        rr_ids[0] = 3'd1;  rr_ids[1] = 3'd2;  rr_ids[2] = 3'd3;  rr_ids[3] = 3'd0;
        rr_pend[0] = 8'h0D; rr_pend[1] = 8'h09; rr_pend[2] = 8'h01; rr_pend[3] = 8'h00;

        do_reset();
        @(negedge clk);
        #1;
        check_value("reset.interrupt", 0, {7'b0, bus_if.interrupt}, 8'h00);
        bus_if.port_id = BASE | {6'b0, OFS_PENDING}; #1;
        check_value("reset.pending", 0, bus_if.in_port, 8'h00);
        bus_if.port_id = BASE | {6'b0, OFS_MASK}; #1;
        check_value("reset.mask", 0, bus_if.in_port, 8'h00);
        bus_if.port_id = BASE | {6'b0, OFS_CURID}; #1;
        check_value("reset.curid", 0, bus_if.in_port, 8'h00);
        bus_if.port_id = 8'h20; #1;
        check_value("in_sel.miss", 0, {7'b0, bus_if.in_sel}, 8'h00);
        bus_if.port_id = 8'h13; #1;
        check_value("in_sel.hit", 0, {7'b0, bus_if.in_sel}, 8'h01);

`ifdef PICO_INTC_RR_EN
        v = '{1'b1, OFS_MASK, 8'h0F, 4'b0000, 1'b0, OFS_MASK, 8'h0F, 1'b0};
        run_step("rr.mask", 0, v);
        v = '{1'b0, OFS_PENDING, 8'h00, 4'b1111, 1'b0, OFS_PENDING, 8'h0F, 1'b0};
        run_step("rr.raise", 0, v);
        v = '{1'b0, OFS_PENDING, 8'h00, 4'b0000, 1'b0, OFS_PENDING, 8'h0F, 1'b1};
        run_step("rr.req", 0, v);
        for (int k = 0; k < 4; k++) begin
            v = '{1'b0, OFS_PENDING, 8'h00, 4'b0000, 1'b1, OFS_CURID, {5'b10000, rr_ids[k]}, 1'b0};
            run_step("rr.ack", k, v);
            v = '{1'b1, OFS_EOI, 8'h00, 4'b0000, 1'b0, OFS_PENDING, rr_pend[k], 1'b0};
            run_step("rr.eoi", k, v);
            v = '{1'b0, OFS_PENDING, 8'h00, 4'b0000, 1'b0, OFS_PENDING, rr_pend[k], (k < 3)};
            run_step("rr.rereq", k, v);
        end
`else
        for (int i = 0; i < 32; i++) begin
            run_step("vec", i, vecs[i]);
        end
`endif

        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_step("rst_seq", i, rst_seq[i]);
        end
        @(negedge clk);
        irq_src = '0;
        reset_n = 1'b0;
        #1;
        check_value("async_rst.interrupt", 0, {7'b0, bus_if.interrupt}, 8'h00);
        bus_if.port_id = BASE | {6'b0, OFS_PENDING}; #1;
        check_value("async_rst.pending", 0, bus_if.in_port, 8'h00);
        bus_if.port_id = BASE | {6'b0, OFS_MASK}; #1;
        check_value("async_rst.mask", 0, bus_if.in_port, 8'h00);
        bus_if.port_id = BASE | {6'b0, OFS_CURID}; #1;
        check_value("async_rst.curid", 0, bus_if.in_port, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
